// File: rtl/prescaler_if.sv
// ============================================================================
//  Module   : prescaler_if
//  Purpose  : Control/status bundle for the programmable CE prescaler.
//  Ports    : ce, sclr, div, load, mode, start   (driven by master)
//             ceo, busy, cnt [, tog]              (driven by prescaler)
//  Options  : PRESC_TOGGLE_EN adds the tog square-wave output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface prescaler_if #(
  parameter int WIDTH = 16
);
  logic             ce;
  logic             sclr;
  logic [WIDTH-1:0] div;
  logic             load;
  logic             mode;
  logic             start;
  logic             ceo;
  logic             busy;
  logic [WIDTH-1:0] cnt;
`ifdef PRESC_TOGGLE_EN
  logic             tog;
`endif

  modport master (
    output ce, sclr, div, load, mode, start,
`ifdef PRESC_TOGGLE_EN
    input  tog,
`endif
    input  ceo, busy, cnt
  );

  modport slave (
    input  ce, sclr, div, load, mode, start,
`ifdef PRESC_TOGGLE_EN
    output tog,
`endif
    output ceo, busy, cnt
  );
endinterface

`default_nettype wire

// File: rtl/prescaler_prog.sv
// ============================================================================
//  Module   : prescaler_prog
//  Purpose  : Runtime-programmable clock-enable prescaler. Emits a one-cycle
//             ceo every div_e-th ce, in continuous or one-shot mode. The
//             divide value is loaded into a shadow register and only takes
//             effect at a period boundary (terminal count, sclr, shot start).
//  Ports    : clk_i   system clock, rising edge
//             rst_ni  asynchronous active-low reset
//             bus     prescaler_if.slave (ce/sclr/div/load/mode/start in,
//                     ceo/busy/cnt[/tog] out)
//  Options  : PRESC_TOGGLE_EN adds tog, toggling on every ceo.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prescaler_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 15
) (
  input  wire          clk_i,
  input  wire          rst_ni,
  prescaler_if.slave   bus
);

  localparam logic [WIDTH-1:0] C_DEF_DIV = DEFAULT_DIV[WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_FREE = 2'd1,
    RUN_SHOT = 2'd2
  } state_t;

  state_t           state_q, state_d, w_state;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_r_q, div_r_d;
  logic [WIDTH-1:0] div_s_q;
  logic [WIDTH-1:0] w_div_e;
  logic             w_term;
  logic             w_ceo;

  // Continuous mode overrides the stored state immediately, so a fresh reset
  // with mode=0 is already counting on the first ce.
  always_comb begin
    w_state = bus.mode ? state_q : RUN_FREE;
    w_div_e = (div_r_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : div_r_q;
    w_term  = (w_state != IDLE) && (cnt_q == w_div_e - 1'b1);
    w_ceo   = bus.ce && w_term && !bus.sclr;
  end

  always_comb begin
    state_d = w_state;
    cnt_d   = cnt_q;
    div_r_d = div_r_q;
    if (bus.sclr) begin
      cnt_d   = '0;
      div_r_d = div_s_q;
      state_d = bus.mode ? IDLE : RUN_FREE;
    end else begin
      case (w_state)
        IDLE: begin
          cnt_d = '0;
          if (bus.start) begin
            state_d = RUN_SHOT;
            div_r_d = div_s_q;
          end
        end
        RUN_FREE, RUN_SHOT: begin
          if (bus.ce) begin
            if (w_term) begin
              cnt_d   = '0;
              div_r_d = div_s_q;
              // A free-running divider switched to one-shot stops here,
              // after delivering the pulse of the period it was in.
              state_d = (w_state == RUN_SHOT || bus.mode) ? IDLE : RUN_FREE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_r_q <= C_DEF_DIV;
      div_s_q <= C_DEF_DIV;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_r_q <= div_r_d;
      // Shadow capture is independent of sclr and of the terminal count;
      // a same-cycle transfer above still uses the previous shadow value.
      if (bus.load) begin
        div_s_q <= bus.div;
      end
    end
  end

  assign bus.ceo  = w_ceo;
  assign bus.busy = (w_state != IDLE);
  assign bus.cnt  = cnt_q;

`ifdef PRESC_TOGGLE_EN
  logic tog_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tog_q <= 1'b0;
    end else if (bus.sclr) begin
      tog_q <= 1'b0;
    end else if (w_ceo) begin
      tog_q <= ~tog_q;
    end
  end

  assign bus.tog = tog_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prescaler_prog.sv
// ============================================================================
//  Module   : tb_prescaler_prog
//  Purpose  : Self-checking bench for prescaler_prog (directed vectors).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prescaler_prog;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  prescaler_if #(.WIDTH(W)) bus_if ();

  prescaler_prog #(.WIDTH(W), .DEFAULT_DIV(15)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ce;
    logic         sclr;
    logic         load;
    logic [W-1:0] div;
    logic         mode;
    logic         start;
    logic         eceo;
    logic         ebusy;
    logic [W-1:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive inputs after the falling edge, then compare outputs for that cycle
  // (state from the previous rising edge, combined with the new inputs).
  task automatic vec(input logic ce, input logic sclr, input logic load,
                     input logic [W-1:0] div, input logic mode, input logic start,
                     input logic eceo, input logic ebusy, input logic [W-1:0] ecnt,
                     input string tag);
    @(negedge clk);
    bus_if.ce    = ce;
    bus_if.sclr  = sclr;
    bus_if.load  = load;
    bus_if.div   = div;
    bus_if.mode  = mode;
    bus_if.start = start;
    #1;
    chk({tag, ".ceo"},  {{(W-1){1'b0}}, bus_if.ceo},  {{(W-1){1'b0}}, eceo});
    chk({tag, ".busy"}, {{(W-1){1'b0}}, bus_if.busy}, {{(W-1){1'b0}}, ebusy});
    chk({tag, ".cnt"},  bus_if.cnt, ecnt);
  endtask

  task automatic add(input logic ce, input logic load, input logic [W-1:0] div,
                     input logic mode, input logic start,
                     input logic eceo, input logic ebusy, input logic [W-1:0] ecnt);
    vec_t v;
    v.ce = ce; v.sclr = 1'b0; v.load = load; v.div = div; v.mode = mode;
    v.start = start; v.eceo = eceo; v.ebusy = ebusy; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  initial begin
    // Load 3 while dividing by 1: old shadow (0) moves first, 3 next pulse.
    add(1, 1, 3, 0, 0,  1, 1, 0);
    add(1, 0, 0, 0, 0,  1, 1, 0);
    // Gated ce, divide by 3: ceo every 6 clocks, only with ce=1.
    add(1, 0, 0, 0, 0,  0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 1, 1);
    add(1, 0, 0, 0, 0,  0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 1, 2);
    add(1, 0, 0, 0, 0,  1, 1, 2);
    add(0, 0, 0, 0, 0,  0, 1, 0);
    add(1, 0, 0, 0, 0,  0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 1, 1);
    add(1, 0, 0, 0, 0,  0, 1, 1);
    add(0, 0, 0, 0, 0,  0, 1, 2);
    add(1, 0, 0, 0, 0,  1, 1, 2);
    add(0, 0, 0, 0, 0,  0, 1, 0);
    // Switch to one-shot mid-period: the divide-by-3 period completes, then idle.
    add(0, 1, 5, 1, 0,  0, 1, 0);
    add(1, 0, 0, 1, 0,  0, 1, 0);
    add(1, 0, 0, 1, 0,  0, 1, 1);
    add(1, 0, 0, 1, 0,  1, 1, 2);
    add(1, 0, 0, 1, 0,  0, 0, 0);
    // One-shot of 5, retrigger at cnt=2 ignored.
    add(1, 0, 0, 1, 1,  0, 0, 0);
    add(1, 0, 0, 1, 0,  0, 1, 0);
    add(1, 0, 0, 1, 0,  0, 1, 1);
    add(1, 0, 0, 1, 1,  0, 1, 2);
    add(1, 0, 0, 1, 0,  0, 1, 3);
    add(1, 0, 0, 1, 0,  1, 1, 4);
    add(1, 0, 0, 1, 0,  0, 0, 0);
    // START with ce=0 is still accepted; counting waits for ce.
    add(0, 0, 0, 1, 1,  0, 0, 0);
    add(0, 0, 0, 1, 0,  0, 1, 0);
    add(1, 0, 0, 1, 0,  0, 1, 0);
    // mode back to 0 forces free-running, counting continues.
    add(1, 0, 0, 0, 0,  0, 1, 1);

    bus_if.ce = 0; bus_if.sclr = 0; bus_if.load = 0; bus_if.div = '0;
    bus_if.mode = 1; bus_if.start = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.cnt",  bus_if.cnt, '0);
    chk("rst.busy", {{(W-1){1'b0}}, bus_if.busy}, '0);
    chk("rst.ceo",  {{(W-1){1'b0}}, bus_if.ceo},  '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.mode = 0;

    // Default divide 15, with runtime loads of 4 (at cnt=5) and 0 (at cnt=1).
    for (int i = 0; i < 23; i++) begin
      logic [W-1:0] ec;
      logic         eo;
      if (i < 15)      begin ec = W'(i);      eo = (i == 14); end
      else if (i < 19) begin ec = W'(i - 15); eo = (i == 18); end
      else             begin ec = '0;         eo = 1'b1;      end
      vec(1, 0, (i == 5) || (i == 16), (i == 5) ? W'(4) : '0, 0, 0, eo, 1, ec, "dflt_load");
    end

    foreach (tbl[k])
      vec(tbl[k].ce, tbl[k].sclr, tbl[k].load, tbl[k].div, tbl[k].mode, tbl[k].start,
          tbl[k].eceo, tbl[k].ebusy, tbl[k].ecnt, $sformatf("tbl%0d", k));

    // SCLR mid-period (cnt=7, div 15), then a clean 15-cycle period.
    vec(0, 0, 1, 15, 0, 0,  0, 1, 2, "sclr.ld");
    vec(1, 1, 0, 0,  0, 0,  0, 1, 2, "sclr.apply");
    for (int j = 0; j < 7; j++) vec(1, 0, 0, 0, 0, 0, 0, 1, W'(j), "sclr.pre");
    vec(1, 1, 0, 0, 0, 0, 0, 1, 7, "sclr.mid");
    for (int j = 0; j < 15; j++) vec(1, 0, 0, 0, 0, 0, (j == 14), 1, W'(j), "sclr.per");
    // SCLR on the terminal cycle suppresses ceo.
    for (int j = 0; j < 15; j++) vec(1, (j == 14), 0, 0, 0, 0, 1'b0, 1, W'(j), "sclr.term");

    // Async reset mid-period restores the default divide.
    vec(0, 0, 1, 4, 0, 0, 0, 1, 0, "ar.ld4");
    vec(0, 1, 0, 0, 0, 0, 0, 1, 0, "ar.sclr");
    vec(1, 0, 0, 0, 0, 0, 0, 1, 0, "ar.c0");
    vec(1, 0, 0, 0, 0, 0, 0, 1, 1, "ar.c1");
    @(negedge clk);
    #2;
    bus_if.mode = 1;
    rst_n = 1'b0;
    #1;
    chk("ar.cnt",  bus_if.cnt, '0);
    chk("ar.busy", {{(W-1){1'b0}}, bus_if.busy}, '0);
    chk("ar.ceo",  {{(W-1){1'b0}}, bus_if.ceo},  '0);
    @(negedge clk);
    bus_if.ce = 0;
    bus_if.mode = 0;
    rst_n = 1'b1;
    for (int j = 0; j < 15; j++) vec(1, 0, 0, 0, 0, 0, (j == 14), 1, W'(j), "ar.per");

`ifdef PRESC_TOGGLE_EN
    vec(0, 0, 1, 2, 0, 0, 0, 1, 0, "tog.ld");
    vec(0, 1, 0, 0, 0, 0, 0, 1, 0, "tog.sclr");
    for (int i = 0; i < 8; i++) begin
      vec(1, 0, 0, 0, 0, 0, (i % 2 == 1), 1, W'(i % 2), "tog.run");
      chk("tog.val", {{(W-1){1'b0}}, bus_if.tog}, W'((i / 2) % 2));
    end
    vec(1, 1, 0, 0, 0, 0, 0, 1, 0, "tog.clr");
    vec(0, 0, 0, 0, 0, 0, 0, 1, 0, "tog.after");
    chk("tog.cleared", {{(W-1){1'b0}}, bus_if.tog}, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
